// File: rtl/uart_rx_parity.sv
// Oversampling UART receiver with selectable 5-8 data bits, optional even parity,
// framing-error detection and line-break handling.
module uart_rx_parity #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick,
    input  logic       rx,
    input  logic [1:0] num_data,
    input  logic       parity_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] TICK_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] TICK_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Keeps only the bits that belong to a word of the selected length.
    function automatic logic [7:0] width_mask(input logic [1:0] sel);
        logic [7:0] m;
        case (sel)
            2'b00:   m = 8'h1F;
            2'b01:   m = 8'h3F;
            2'b10:   m = 8'h7F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   tick_r, tick_s;
    logic [2:0]      bit_r, bit_s;
    logic [2:0]      last_bit_s;
    logic [7:0]      shift_r, shift_s;
    logic            calc_par_r, calc_par_s;
    logic            perr_r, perr_s;
    logic [1:0]      lat_num_r, lat_num_s;
    logic            lat_par_r, lat_par_s;
    logic            rx_meta_r, rxs_r;
    logic [7:0]      rx_data_r, rx_data_s;
    logic            rx_valid_r, rx_valid_s;
    logic            parity_err_r, parity_err_s;
    logic            frame_err_r, frame_err_s;
    logic            busy_r, busy_s;

    assign last_bit_s = 3'd4 + {1'b0, lat_num_r};

    // Next-state, counter and output-capture logic; frame settings are taken from the latched copies.
    always_comb begin
        state_s      = state_r;
        tick_s       = tick_r;
        bit_s        = bit_r;
        shift_s      = shift_r;
        calc_par_s   = calc_par_r;
        perr_s       = perr_r;
        lat_num_s    = lat_num_r;
        lat_par_s    = lat_par_r;
        rx_data_s    = rx_data_r;
        rx_valid_s   = 1'b0;
        parity_err_s = parity_err_r;
        frame_err_s  = frame_err_r;
        if (baud_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_s    = ST_START;
                        tick_s     = '0;
                        bit_s      = 3'd0;
                        shift_s    = 8'h00;
                        calc_par_s = 1'b0;
                        perr_s     = 1'b0;
                        lat_num_s  = num_data;
                        lat_par_s  = parity_en;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (tick_r == TICK_HALF) begin
                        tick_s  = '0;
                        state_s = rxs_r ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_r == TICK_LAST) begin
                        tick_s         = '0;
                        shift_s[bit_r] = rxs_r;
                        calc_par_s     = calc_par_r ^ rxs_r;
                        if (bit_r == last_bit_s) begin
                            bit_s   = 3'd0;
                            state_s = lat_par_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end
                ST_PARITY: begin
                    if (tick_r == TICK_LAST) begin
                        tick_s  = '0;
                        perr_s  = rxs_r ^ calc_par_r;
                        state_s = ST_STOP;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end
                ST_STOP: begin
                    if (tick_r == TICK_LAST) begin
                        tick_s       = '0;
                        rx_valid_s   = 1'b1;
                        rx_data_s    = shift_r & width_mask(lat_num_r);
                        parity_err_s = perr_r;
                        frame_err_s  = ~rxs_r;
                        state_s      = rxs_r ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end
                ST_BREAK: begin
                    if (rxs_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BREAK;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    tick_s  = '0;
                    bit_s   = 3'd0;
                end
            endcase
        end else begin
            rx_valid_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, synchronizer and registered outputs; the synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r    <= 1'b1;
            rxs_r        <= 1'b1;
            state_r      <= ST_IDLE;
            tick_r       <= '0;
            bit_r        <= 3'd0;
            shift_r      <= 8'h00;
            calc_par_r   <= 1'b0;
            perr_r       <= 1'b0;
            lat_num_r    <= 2'b00;
            lat_par_r    <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_valid_r   <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_meta_r    <= rx;
            rxs_r        <= rx_meta_r;
            state_r      <= state_s;
            tick_r       <= tick_s;
            bit_r        <= bit_s;
            shift_r      <= shift_s;
            calc_par_r   <= calc_par_s;
            perr_r       <= perr_s;
            lat_num_r    <= lat_num_s;
            lat_par_r    <= lat_par_s;
            rx_data_r    <= rx_data_s;
            rx_valid_r   <= rx_valid_s;
            parity_err_r <= parity_err_s;
            frame_err_r  <= frame_err_s;
            busy_r       <= busy_s;
        end
    end

    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
